nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit unsigned adder that sequences one 4-bit ripple-carry adder,
// one nibble per cycle, behind a start/busy/done handshake.

module RCA (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = cin_i;
    sum_o    = '0;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cReg_q, cReg_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0]       rcaSum;
  logic             rcaCout;
  logic [WIDTH+3:0] accCat;
  logic [WIDTH-1:0] accNext;

  RCA u_rca (
    .a_i   (aSh_q[3:0]),
    .b_i   (bSh_q[3:0]),
    .cin_i (cReg_q),
    .sum_o (rcaSum),
    .cout_o(rcaCout)
  );

  // New nibble enters at the top so the first one computed lands in the LSBs;
  // concatenating first keeps this valid for WIDTH=4.
  assign accCat  = {rcaSum, acc_q};
  assign accNext = accCat[WIDTH+3:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    aSh_d  = aSh_q;
    bSh_d  = bSh_q;
    acc_d  = acc_q;
    cReg_d = cReg_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d  = a;
          bSh_d  = b;
          cReg_d = cin;
          cnt_d  = '0;
          acc_d  = '0;
        end
      end
      RUN: begin
        aSh_d  = aSh_q >> 4;
        bSh_d  = bSh_q >> 4;
        acc_d  = accNext;
        cReg_d = rcaCout;
        cnt_d  = cnt_q + CW'(1);
        // Result becomes visible only on the edge that enters DONE.
        if (cnt_q == LAST) begin
          sum_d  = accNext;
          cout_d = rcaCout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh_q  <= '0;
      bSh_q  <= '0;
      acc_q  <= '0;
      cReg_q <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      aSh_q  <= aSh_d;
      bSh_q  <= bSh_d;
      acc_q  <= acc_d;
      cReg_q <= cReg_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16, plus random sweeps of
// WIDTH=4 and WIDTH=32 instances sharing the same clock and reset.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        start32 = 1'b0, cin32 = 1'b0, busy32, done32, cout32;
  logic [31:0] a32 = '0, b32 = '0, sum32;

  logic [32:0] q16[$];
  logic [32:0] q4[$];
  logic [32:0] q32[$];
  logic [16:0] lastRes16 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  // Presents one request in the IDLE cycle and records its expected result.
  task automatic kick16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    @(negedge clk);
    start16 = 1'b1;
    a16 = av;
    b16 = bv;
    cin16 = cv;
    q16.push_back(33'(av) + 33'(bv) + 33'(cv));
    @(posedge clk);
    #1 start16 = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done; lat stays -1 on timeout.
  task automatic wait_done16(input logic [16:0] held, output int lat,
                             output int busyBad, output int sumBad);
    lat = -1;
    busyBad = 0;
    sumBad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done16) begin
        lat = k;
        break;
      end
      if (!busy16) busyBad++;
      if ({cout16, sum16} !== held) sumBad++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy16, done16, cout16, sum16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy16, done16} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_after_release: got busy=%b done=%b, want 0 0", busy16, done16);
    end
  endtask

  task automatic test_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input string name);
    int lat, busyBad, sumBad;
    logic [32:0] exp;
    kick16(av, bv, cv);
    wait_done16(lastRes16, lat, busyBad, sumBad);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL %s_latency: done after %0d cycles, want 4", name, lat);
    end
    checks++;
    if (busyBad !== 0 || sumBad !== 0) begin
      errors++;
      $display("[TB] FAIL %s_busy_hold: busy-low cycles=%0d early sum changes=%0d, want 0 0",
               name, busyBad, sumBad);
    end
    exp = q16.pop_front();
    checks++;
    if ({cout16, sum16} !== exp[16:0]) begin
      errors++;
      $display("[TB] FAIL %s_result: got cout=%b sum=%h, want cout=%b sum=%h",
               name, cout16, sum16, exp[16], exp[15:0]);
    end
    lastRes16 = exp[16:0];
    @(negedge clk);
    checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b0 || {cout16, sum16} !== lastRes16) begin
      errors++;
      $display("[TB] FAIL %s_after_done: got done=%b busy=%b sum=%h, want 0 0 %h",
               name, done16, busy16, sum16, lastRes16[15:0]);
    end
  endtask

  task automatic test_basic();
    test_add(16'h1234, 16'h4321, 1'b0, "basic");
    checks++;
    if ({cout16, sum16} !== 17'h05555) begin
      errors++;
      $display("[TB] FAIL basic_const: got %h, want 05555", {cout16, sum16});
    end
  endtask

  task automatic test_carry_chain();
    test_add(16'hFFFF, 16'h0001, 1'b0, "carry_b");
    test_add(16'hFFFF, 16'h0000, 1'b1, "carry_cin");
    checks++;
    if ({cout16, sum16} !== 17'h10000) begin
      errors++;
      $display("[TB] FAIL carry_const: got %h, want 10000", {cout16, sum16});
    end
  endtask

  task automatic test_back_to_back();
    int lat, busyBad, sumBad;
    logic [32:0] exp;
    @(negedge clk);
    start16 = 1'b1;
    a16 = 16'h00FF;
    b16 = 16'h0F01;
    cin16 = 1'b0;
    q16.push_back(33'h0_0000_1000);
    @(posedge clk);
    #1;
    a16 = 16'h8000;
    b16 = 16'h8000;
    q16.push_back(33'h0_0001_0000);
    wait_done16(lastRes16, lat, busyBad, sumBad);
    exp = q16.pop_front();
    checks++;
    if (lat !== 4 || {cout16, sum16} !== exp[16:0]) begin
      errors++;
      $display("[TB] FAIL b2b_first: lat=%0d sum=%h cout=%b, want lat=4 sum=%h cout=%b",
               lat, sum16, cout16, exp[15:0], exp[16]);
    end
    lastRes16 = exp[16:0];
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || {cout16, sum16} !== lastRes16) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap: busy=%b done=%b sum=%h, want 0 0 %h",
               busy16, done16, sum16, lastRes16[15:0]);
    end
    @(posedge clk);
    #1 start16 = 1'b0;
    wait_done16(lastRes16, lat, busyBad, sumBad);
    exp = q16.pop_front();
    checks++;
    if (lat !== 4 || sumBad !== 0 || {cout16, sum16} !== exp[16:0]) begin
      errors++;
      $display("[TB] FAIL b2b_second: lat=%0d early changes=%0d sum=%h cout=%b, want lat=4 0 sum=%h cout=%b",
               lat, sumBad, sum16, cout16, exp[15:0], exp[16]);
    end
    lastRes16 = exp[16:0];
  endtask

  task automatic test_ignore_start();
    int doneCount = 0;
    logic [32:0] exp;
    kick16(16'h2222, 16'h1111, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done16) begin
        doneCount++;
        exp = q16.pop_front();
        checks++;
        if ({cout16, sum16} !== exp[16:0]) begin
          errors++;
          $display("[TB] FAIL ignore_result: got cout=%b sum=%h, want cout=%b sum=%h",
                   cout16, sum16, exp[16], exp[15:0]);
        end
        lastRes16 = exp[16:0];
      end
      if (busy16 || (done16 && doneCount == 1 && k < 6)) begin
        start16 = 1'b1;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        cin16 = 1'($urandom);
      end else begin
        start16 = 1'b0;
      end
    end
    start16 = 1'b0;
    checks++;
    if (doneCount !== 1 || busy16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_single_done: done pulses=%0d busy=%b, want 1 0",
               doneCount, busy16);
    end
  endtask

  task automatic test_reset_midrun();
    int doneSeen = 0;
    int lat, busyBad, sumBad;
    logic [32:0] exp;
    kick16(16'h1234, 16'h4321, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy16 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_busy: got busy=%b, want 1", busy16);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL midrun_async_clear: busy=%b done=%b cout=%b sum=%h, want all 0",
               busy16, done16, cout16, sum16);
    end
    q16.delete();
    lastRes16 = '0;
    repeat (3) begin
      @(negedge clk);
      if (done16) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done16) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: saw %0d done pulses, want 0", doneSeen);
    end
    kick16(16'h0001, 16'h0001, 1'b0);
    wait_done16(lastRes16, lat, busyBad, sumBad);
    exp = q16.pop_front();
    checks++;
    if (lat !== 4 || {cout16, sum16} !== 17'h00002 || exp[16:0] !== 17'h00002) begin
      errors++;
      $display("[TB] FAIL midrun_recover: lat=%0d cout=%b sum=%h, want lat=4 cout=0 sum=0002",
               lat, cout16, sum16);
    end
    lastRes16 = exp[16:0];
  endtask

  task automatic test_sweep16(input int n);
    int lat, busyBad, sumBad;
    logic [32:0] exp;
    for (int i = 0; i < n; i++) begin
      kick16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done16(lastRes16, lat, busyBad, sumBad);
      exp = q16.pop_front();
      checks++;
      if (lat !== 4 || {cout16, sum16} !== exp[16:0]) begin
        errors++;
        $display("[TB] FAIL sweep16[%0d]: lat=%0d got %h, want lat=4 %h",
                 i, lat, {cout16, sum16}, exp[16:0]);
      end
      lastRes16 = exp[16:0];
    end
  endtask

  task automatic test_sweep4(input int n);
    int lat;
    logic [32:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start4 = 1'b1;
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom);
      q4.push_back(33'(a4) + 33'(b4) + 33'(cin4));
      @(posedge clk);
      #1 start4 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done4) begin
          lat = k;
          break;
        end
      end
      exp = q4.pop_front();
      checks++;
      if (lat !== 1 || {cout4, sum4} !== exp[4:0]) begin
        errors++;
        $display("[TB] FAIL sweep4[%0d]: lat=%0d got %h, want lat=1 %h",
                 i, lat, {cout4, sum4}, exp[4:0]);
      end
    end
  endtask

  task automatic test_sweep32(input int n);
    int lat;
    logic [32:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start32 = 1'b1;
      a32 = $urandom;
      b32 = $urandom;
      cin32 = 1'($urandom);
      q32.push_back(33'(a32) + 33'(b32) + 33'(cin32));
      @(posedge clk);
      #1 start32 = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done32) begin
          lat = k;
          break;
        end
      end
      exp = q32.pop_front();
      checks++;
      if (lat !== 8 || {cout32, sum32} !== exp) begin
        errors++;
        $display("[TB] FAIL sweep32[%0d]: lat=%0d got %h, want lat=8 %h",
                 i, lat, {cout32, sum32}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_ignore_start();
    test_reset_midrun();
    test_sweep16(2000);
    test_sweep4(1000);
    test_sweep32(1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a hang if the design never completes a handshake.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
